// File: rtl/act_pla_pkg.sv
// Shared constants for the piecewise-linear tanh/sigmoid pipeline.
package act_pla_pkg;

    // Operand mode, carried alongside each operand through the pipe.
    localparam logic MODE_TANH = 1'b0;
    localparam logic MODE_SIGM = 1'b1;

    // Fraction weights of the segment slope: f/2 + f/4, realised as right shifts.
    localparam int unsigned FRAC_W1_SH = 1;
    localparam int unsigned FRAC_W2_SH = 2;

endpackage

// File: rtl/act_pla_core.sv
// Combinational magnitude-to-t mapping: t = 1 - 2^(-2k) * (1 - f/2 - f/4).
module act_pla_core
    import act_pla_pkg::*;
#(
    parameter int unsigned W_IN  = 16,
    parameter int unsigned IN_I  = 4,
    parameter int unsigned W_OUT = 16,
    parameter int unsigned SAT_K = 4
) (
    input  logic [W_IN-1:0]  mag_i,
    input  logic             is_min_i,
    output logic [W_OUT-2:0] t_mag_o,
    output logic             sat_o
);

    localparam int unsigned IN_F  = W_IN - IN_I;
    localparam int unsigned OUT_F = W_OUT - 1;
    // Wide enough that f/2, f/4 and the 2k shift stay exact before the final truncation.
    localparam int unsigned P     = IN_F + OUT_F;

    logic [IN_I-1:0] k;
    logic [IN_F-1:0] f;
    logic [P:0]      one;
    logic [P:0]      f_p;
    logic [P:0]      e;
    logic [P:0]      g;
    logic [P:0]      t;
    logic            unused_t;

    // Shift-add evaluation of the segment, then truncation toward zero.
    always_comb begin
        k        = mag_i[W_IN-1:IN_F];
        f        = mag_i[IN_F-1:0];
        one      = '0;
        one[P]   = 1'b1;
        f_p      = {{(OUT_F + 1){1'b0}}, f} << OUT_F;
        e        = one - (f_p >> FRAC_W1_SH) - (f_p >> FRAC_W2_SH);
        g        = e >> {k, 1'b0};
        t        = one - g;
        sat_o    = (32'(k) >= SAT_K) || is_min_i;
        t_mag_o  = sat_o ? '1 : t[P-1:IN_F];
        unused_t = ^{t[P], t[IN_F-1:0]};
    end

endmodule

// File: rtl/act_pla_pipe.sv
// Three-stage valid/ready pipeline for tanh/sigmoid with a saturation counter.
module act_pla_pipe
    import act_pla_pkg::*;
#(
    parameter int unsigned W_IN  = 16,
    parameter int unsigned IN_I  = 4,
    parameter int unsigned W_OUT = 16,
    parameter int unsigned SAT_K = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_IN-1:0]  in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_OUT-1:0] out_data,
    output logic [CNT_W-1:0] sat_count
);

    localparam int unsigned OUT_F = W_OUT - 1;

    // S1: magnitude of the (prescaled) operand
    logic             s1_valid_q, s1_valid_d;
    logic [W_IN-1:0]  s1_mag_q, s1_mag_d;
    logic             s1_neg_q, s1_neg_d;
    logic             s1_min_q, s1_min_d;
    logic             s1_mode_q, s1_mode_d;
    // S2: unsigned t
    logic             s2_valid_q, s2_valid_d;
    logic [OUT_F-1:0] s2_t_q, s2_t_d;
    logic             s2_sat_q, s2_sat_d;
    logic             s2_neg_q, s2_neg_d;
    logic             s2_mode_q, s2_mode_d;
    // S3: final result
    logic             s3_valid_q, s3_valid_d;
    logic [W_OUT-1:0] s3_data_q, s3_data_d;
    logic             s3_sat_q, s3_sat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             ld1, ld2, ld3;
    logic signed [W_IN-1:0] x_s, x_p;
    logic [W_IN-1:0]  mag;
    logic             x_neg, x_min;
    logic [OUT_F-1:0] core_t;
    logic             core_sat;
    logic [W_OUT-1:0] y_t, y_s, half;

    act_pla_core #(
        .W_IN  (W_IN),
        .IN_I  (IN_I),
        .W_OUT (W_OUT),
        .SAT_K (SAT_K)
    ) u_core (
        .mag_i    (s1_mag_q),
        .is_min_i (s1_min_q),
        .t_mag_o  (core_t),
        .sat_o    (core_sat)
    );

    // Handshake: a stage loads when empty or when its content moves on this cycle.
    always_comb begin
        ld3      = !s3_valid_q || out_ready;
        ld2      = !s2_valid_q || ld3;
        ld1      = !s1_valid_q || ld2;
        in_ready = ld1;
    end

    // Datapath: prescale/abs feeding S1, sign/offset feeding S3.
    always_comb begin
        x_s   = in_data;
        x_p   = (in_mode == MODE_TANH) ? x_s : (x_s >>> 1);
        x_neg = x_p[W_IN-1];
        mag   = x_neg ? -x_p : x_p;
        x_min = (x_p == {1'b1, {(W_IN - 1){1'b0}}});

        half           = '0;
        half[W_OUT-2]  = 1'b1;
        y_t            = s2_neg_q ? -{1'b0, s2_t_q} : {1'b0, s2_t_q};
        y_s            = half + {y_t[W_OUT-1], y_t[W_OUT-1:1]};
    end

    // Next-state: stalled stages hold, loading stages take upstream content.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mag_d   = s1_mag_q;
        s1_neg_d   = s1_neg_q;
        s1_min_d   = s1_min_q;
        s1_mode_d  = s1_mode_q;
        s2_valid_d = s2_valid_q;
        s2_t_d     = s2_t_q;
        s2_sat_d   = s2_sat_q;
        s2_neg_d   = s2_neg_q;
        s2_mode_d  = s2_mode_q;
        s3_valid_d = s3_valid_q;
        s3_data_d  = s3_data_q;
        s3_sat_d   = s3_sat_q;
        cnt_d      = cnt_q;

        if (ld1) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_mag_d  = mag;
                s1_neg_d  = x_neg;
                s1_min_d  = x_min;
                s1_mode_d = in_mode;
            end
        end
        if (ld2) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_t_d    = core_t;
                s2_sat_d  = core_sat;
                s2_neg_d  = s1_neg_q;
                s2_mode_d = s1_mode_q;
            end
        end
        if (ld3) begin
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                s3_data_d = (s2_mode_q == MODE_SIGM) ? y_s : y_t;
                s3_sat_d  = s2_sat_q;
            end
        end
        // Count delivered saturated results, sticking at all-ones.
        if (s3_valid_q && out_ready && s3_sat_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s1_mag_q   <= '0;
            s1_neg_q   <= 1'b0;
            s1_min_q   <= 1'b0;
            s1_mode_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_t_q     <= '0;
            s2_sat_q   <= 1'b0;
            s2_neg_q   <= 1'b0;
            s2_mode_q  <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_data_q  <= '0;
            s3_sat_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mag_q   <= s1_mag_d;
            s1_neg_q   <= s1_neg_d;
            s1_min_q   <= s1_min_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            s2_t_q     <= s2_t_d;
            s2_sat_q   <= s2_sat_d;
            s2_neg_q   <= s2_neg_d;
            s2_mode_q  <= s2_mode_d;
            s3_valid_q <= s3_valid_d;
            s3_data_q  <= s3_data_d;
            s3_sat_q   <= s3_sat_d;
            cnt_q      <= cnt_d;
        end
    end

    // Outputs come straight from S3 and the counter.
    always_comb begin
        out_valid = s3_valid_q;
        out_data  = s3_data_q;
        sat_count = cnt_q;
    end

endmodule

// File: doc/act_pla_pipe.md
ACT_PLA_PIPE -- requirements
Module: act_pla_pipe

Interface
REQ-001 Parameter W_IN, default 16: input word length, two's complement.
REQ-002 Parameter IN_I, default 4: input integer bits including sign; IN_F = W_IN-IN_I.
REQ-003 Parameter W_OUT, default 16: output word length, Q1.(W_OUT-1) two's complement; OUT_F = W_OUT-1.
REQ-004 Parameter SAT_K, default 4: magnitude integer part at or above which output saturates.
REQ-005 Parameter CNT_W, default 16: width of the saturation counter.
REQ-006 clock  in  1  single clock, all state on rising edge.
REQ-007 resetn  in  1  asynchronous active-low reset.
REQ-008 in_valid  in  1  input word present.
REQ-009 in_ready  out  1  block accepts input this cycle.
REQ-010 in_data  in  W_IN  operand x.
REQ-011 in_mode  in  1  0 = tanh, 1 = sigmoid; travels with the operand.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  consumer accepts result.
REQ-014 out_data  out  W_OUT  result y.
REQ-015 sat_count  out  CNT_W  number of saturated results delivered.

Function
REQ-016 A transfer occurs on any edge where valid and ready are both high; each accepted operand produces exactly one result, in order.
REQ-017 Three register stages (S1 magnitude/prescale, S2 shift-add, S3 sign/saturate/offset); latency is 3 cycles from input transfer to out_valid when there is no backpressure; throughput is 1 result per cycle.
REQ-018 A stage loads when it is empty or its content moves on in the same cycle; in_ready = !S1_valid || S1 advances; in_ready depends combinationally on out_ready.
REQ-019 A stalled stage holds its data and mode unchanged; out_data stays stable while out_valid && !out_ready.
REQ-020 Sigmoid mode prescales: x' = x >>> 1 (arithmetic); tanh mode uses x' = x.
REQ-021 m = |x'|; k = integer part of m; f = fractional part of m in [0,1).
REQ-022 t = 1 - 2^(-2k) * (1 - f/2 - f/4), using shifts and adds only; magnitude is truncated toward zero to OUT_F bits.
REQ-023 If k >= SAT_K, or x' is the most negative code, then |t| = 1 - 2^-OUT_F (saturated).
REQ-024 tanh result: y = +t for x' >= 0 and y = -t for x' < 0; y is never 0x8000-equivalent.
REQ-025 sigmoid result: y = 2^-1 + (y_tanh >>> 1), truncated; the range is [0, 1-2^-OUT_F].
REQ-026 sat_count increments by 1 on each output transfer whose result was saturated, and holds at all-ones instead of wrapping.

Reset
REQ-027 While resetn is low, all stage valids are 0, out_valid is 0, out_data is 0, sat_count is 0, and in_ready is 1 after release.
REQ-028 Reset asserted mid-stream discards all in-flight operands; no result from before reset appears afterwards.

Structure
REQ-029 Package act_pla_pkg holds the mode encoding constants (MODE_TANH=0, MODE_SIGM=1) and the fraction weights.
REQ-030 Sub-module act_pla_core implements the combinational magnitude-to-t mapping of REQ-021..023; act_pla_pipe owns the handshake, registers and counter.

Verification (W_IN=16, IN_I=4, W_OUT=16, SAT_K=4)
REQ-031 tanh: in_data 0x0000 -> 0x0000; 0x1000 (1.0) -> 0x6000 (0.75), each exactly 3 cycles after acceptance with out_ready=1.
REQ-032 tanh: 0xE800 (-1.5) -> 0x9400 (-0.84375); 0x5000 (5.0) -> 0x7FFF; 0x8000 -> 0x8001; sat_count ends at 2.
REQ-033 sigmoid: 0x0000 -> 0x4000; 0x2000 (2.0) -> 0x7000 (0.875); 0x8000 -> 0x0000.
REQ-034 Backpressure: stream 6 operands back-to-back with out_ready low for cycles 3-7 -> in_ready falls after 3 accepts, no loss or duplication, order preserved, and out_data is stable while stalled.
REQ-035 Reset pulse with 3 operands in flight -> out_valid 0 and sat_count 0 during reset; the next operand produces a correct result with 3-cycle latency.
REQ-036 Counter saturation with CNT_W=2: 5 saturating results -> sat_count sticks at 3.
